// File: rtl/motor_drive_sequencer.sv
// Motor drive sequencer: turns the 4-bit steering command into per-wheel PWM and direction pins,
// with duty slew limiting and a dead-time-guarded timed pivot for 90-degree corners.
module motor_drive_sequencer #(
  parameter int unsigned PWM_PERIOD    = 2500,
  parameter int unsigned DUTY_FULL     = 2000,
  parameter int unsigned DUTY_VEER     = 1200,
  parameter int unsigned DUTY_HARD     = 500,
  parameter int unsigned DUTY_PIVOT    = 1500,
  parameter int unsigned RAMP_STEP     = 50,
  parameter int unsigned RAMP_DIV      = 50_000,
  parameter int unsigned TURN90_CYCLES = 25_000_000,
  parameter int unsigned DEAD_CYCLES   = 5_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] dir,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic       fwd_l,
  output logic       fwd_r,
  output logic       busy,
  output logic       turn_done
);

  localparam int unsigned DW      = $clog2(PWM_PERIOD + 1);
  localparam int unsigned CntMax  = (TURN90_CYCLES > DEAD_CYCLES) ? TURN90_CYCLES : DEAD_CYCLES;
  localparam int unsigned CW      = $clog2(CntMax + 1);
  localparam int unsigned VW      = $clog2(RAMP_DIV + 1);
  localparam int unsigned StepSat = (RAMP_STEP > PWM_PERIOD) ? PWM_PERIOD : RAMP_STEP;

  localparam logic [DW-1:0] DFull      = DW'(DUTY_FULL);
  localparam logic [DW-1:0] DVeer      = DW'(DUTY_VEER);
  localparam logic [DW-1:0] DHard      = DW'(DUTY_HARD);
  localparam logic [DW-1:0] DPivot     = DW'(DUTY_PIVOT);
  localparam logic [DW-1:0] DStep      = DW'(StepSat);
  localparam logic [DW-1:0] PeriodLast = DW'(PWM_PERIOD - 1);
  localparam logic [CW-1:0] DeadLast   = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] TurnLast   = CW'(TURN90_CYCLES - 1);
  localparam logic [VW-1:0] DivLast    = VW'(RAMP_DIV - 1);

  localparam logic [1:0] ActProceed = 2'b00;
  localparam logic [1:0] ActLeft    = 2'b01;
  localparam logic [1:0] ActRight   = 2'b10;
  localparam logic [1:0] ActStop    = 2'b11;
  localparam logic [1:0] MagVeer    = 2'b01;
  localparam logic [1:0] MagHard    = 2'b10;
  localparam logic [1:0] Mag90      = 2'b11;

  typedef enum logic [2:0] {StIdle, StRun, StDeadIn, StPivot, StDeadOut, StStop} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [VW-1:0]  div_q, div_d;
  logic [DW-1:0]  pcnt_q, pcnt_d;
  logic [DW-1:0]  cmd_l_q, cmd_l_d, cmd_r_q, cmd_r_d;
  logic [DW-1:0]  act_l_q, act_l_d, act_r_q, act_r_d;
  logic [DW-1:0]  tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
  logic           pivot_left_q, pivot_left_d;
  logic           fwd_l_q, fwd_l_d, fwd_r_q, fwd_r_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic           pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

  logic [1:0]     action, mag;
  logic [DW-1:0]  inner;
  logic           cnt_done, tick, wrap, pivot_entry, zero_drive;

  assign action = dir[3:2];
  assign mag    = dir[1:0];

  function automatic logic [DW-1:0] ramp_toward(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt);
    logic [DW-1:0] diff;
    if (tgt > cur) begin
      diff = tgt - cur;
      ramp_toward = (diff > DStep) ? cur + DStep : tgt;
    end else begin
      diff = cur - tgt;
      ramp_toward = (diff > DStep) ? cur - DStep : tgt;
    end
  endfunction

  always_comb begin
    inner = DFull;
    if (mag == MagVeer)      inner = DVeer;
    else if (mag == MagHard) inner = DHard;
    tgt_l_d = DFull;
    tgt_r_d = DFull;
    if (action == ActLeft)       tgt_l_d = inner;
    else if (action == ActRight) tgt_r_d = inner;
  end

  // One counter serves every dwell: dead time, pivot duration, idle/stop settle.
  assign cnt_done = (state_q == StPivot) ? (cnt_q == TurnLast) : (cnt_q == DeadLast);
  assign tick     = (div_q == DivLast);
  assign wrap     = (pcnt_q == PeriodLast);

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (cnt_done) state_d = StRun;
        StRun: begin
          if (action == ActStop)                             state_d = StStop;
          else if (action != ActProceed && mag == Mag90)     state_d = StDeadIn;
        end
        StDeadIn: begin
          if (action == ActStop) state_d = StStop;
          else if (cnt_done)     state_d = StPivot;
        end
        StPivot: begin
          if (action == ActStop) state_d = StStop;
          else if (cnt_done)     state_d = StDeadOut;
        end
        StDeadOut: begin
          if (action == ActStop) state_d = StStop;
          else if (cnt_done)     state_d = StRun;
        end
        StStop:   if (cnt_done && action != ActStop) state_d = StRun;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    pivot_entry = (state_d == StPivot) && (state_q != StPivot);
    zero_drive  = state_d inside {StIdle, StDeadIn, StDeadOut, StStop};

    if (state_d != state_q) cnt_d = '0;
    else if (cnt_done)      cnt_d = cnt_q;
    else                    cnt_d = cnt_q + CW'(1);

    div_d = tick ? '0 : div_q + VW'(1);

    if (pivot_entry) pcnt_d = '0;
    else if (wrap)   pcnt_d = '0;
    else             pcnt_d = pcnt_q + DW'(1);

    if (state_q == StRun && state_d == StRun) begin
      cmd_l_d = tick ? ramp_toward(cmd_l_q, tgt_l_q) : cmd_l_q;
      cmd_r_d = tick ? ramp_toward(cmd_r_q, tgt_r_q) : cmd_r_q;
    end else begin
      cmd_l_d = (state_d == StPivot) ? DPivot : '0;
      cmd_r_d = (state_d == StPivot) ? DPivot : '0;
    end

    // Forced-zero and pivot entry bypass the period boundary; normal duty waits for the wrap.
    if (zero_drive) begin
      act_l_d = '0;
      act_r_d = '0;
    end else if (pivot_entry) begin
      act_l_d = DPivot;
      act_r_d = DPivot;
    end else if (wrap) begin
      act_l_d = cmd_l_q;
      act_r_d = cmd_r_q;
    end else begin
      act_l_d = act_l_q;
      act_r_d = act_r_q;
    end

    pivot_left_d = pivot_left_q;
    if (state_q == StRun && state_d == StDeadIn) pivot_left_d = (action == ActLeft);

    fwd_l_d = fwd_l_q;
    fwd_r_d = fwd_r_q;
    if (cnt_done && state_q inside {StIdle, StStop, StDeadOut}) begin
      fwd_l_d = 1'b1;
      fwd_r_d = 1'b1;
    end
    if (state_q == StDeadIn && state_d == StPivot) begin
      if (pivot_left_q) fwd_l_d = 1'b0;
      else              fwd_r_d = 1'b0;
    end

    busy_d  = state_d inside {StDeadIn, StPivot, StDeadOut};
    done_d  = (state_q == StDeadOut) && (state_d == StRun);
    pwm_l_d = (pcnt_d < act_l_d);
    pwm_r_d = (pcnt_d < act_r_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      div_q        <= '0;
      pcnt_q       <= '0;
      cmd_l_q      <= '0;
      cmd_r_q      <= '0;
      act_l_q      <= '0;
      act_r_q      <= '0;
      tgt_l_q      <= '0;
      tgt_r_q      <= '0;
      pivot_left_q <= 1'b0;
      fwd_l_q      <= 1'b1;
      fwd_r_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pwm_l_q      <= 1'b0;
      pwm_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      pcnt_q       <= pcnt_d;
      cmd_l_q      <= cmd_l_d;
      cmd_r_q      <= cmd_r_d;
      act_l_q      <= act_l_d;
      act_r_q      <= act_r_d;
      tgt_l_q      <= tgt_l_d;
      tgt_r_q      <= tgt_r_d;
      pivot_left_q <= pivot_left_d;
      fwd_l_q      <= fwd_l_d;
      fwd_r_q      <= fwd_r_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pwm_l_q      <= pwm_l_d;
      pwm_r_q      <= pwm_r_d;
    end
  end

  assign pwm_l     = pwm_l_q;
  assign pwm_r     = pwm_r_q;
  assign fwd_l     = fwd_l_q;
  assign fwd_r     = fwd_r_q;
  assign busy      = busy_q;
  assign turn_done = done_q;

endmodule
